uart_tx_sched: RTL and testbench

//  - Schedules bytes into the UART TX path (data register + TX FSM) on behalf of two requesters.
//  - ALU requester sends a 2*DATA_WIDTH result as two bytes, low byte first.
//  - Register-file requester sends one byte.
//  - Round-robin arbitration between requesters; one-cycle tx_valid pulse per byte;

---
 rtl/uart_tx_sched_if.sv | 28 ++
 rtl/uart_tx_sched.sv | 138 +++++++++++++
 tb/tb_uart_tx_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the system controller, the byte scheduler and
// the UART TX. The master side drives requests and the UART busy flag.
// The slave side is the scheduler.
interface uart_tx_sched_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    alu_valid;
    logic [2*DATA_WIDTH-1:0] alu_data;
    logic                    alu_ack;
    logic                    reg_valid;
    logic [DATA_WIDTH-1:0]   reg_data;
    logic                    reg_ack;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_valid;
    logic                    tx_busy;
    logic                    sched_busy;
    logic                    timeout_err;

    modport master (
        output alu_valid, alu_data, reg_valid, reg_data, tx_busy,
        input  alu_ack, reg_ack, tx_data, tx_valid, sched_busy, timeout_err
    );

    modport slave (
        input  alu_valid, alu_data, reg_valid, reg_data, tx_busy,
        output alu_ack, reg_ack, tx_data, tx_valid, sched_busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Byte scheduler in front of the UART TX.
// Two requesters are served round-robin: the ALU requester sends a
// double-width result as two bytes (low byte first), and the register
// requester sends one byte. Each byte is loaded with a one-cycle tx_valid
// pulse. The scheduler waits for the UART to report busy and then idle
// before it sends the next byte. If busy never rises, the scheduler aborts
// the remaining bytes of that request.
module uart_tx_sched #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            RST,
    uart_tx_sched_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
    typedef enum logic       {GRANT_ALU, GRANT_REG} grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [2*DW-1:0]   buf_q, buf_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [DW-1:0]     tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              alu_ack_q, alu_ack_d;
    logic              reg_ack_q, reg_ack_d;
    logic              sched_busy_q, sched_busy_d;
    logic              timeout_err_q, timeout_err_d;

    // Next-state and next-output computation for the scheduler FSM
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        buf_d         = buf_q;
        byte_cnt_d    = byte_cnt_q;
        to_cnt_d      = to_cnt_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        alu_ack_d     = 1'b0;
        reg_ack_d     = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie, the ALU wins unless it was the last requester served.
                if (bus.alu_valid && (!bus.reg_valid || last_grant_q == GRANT_REG)) begin
                    buf_d        = bus.alu_data;
                    alu_ack_d    = 1'b1;
                    last_grant_d = GRANT_ALU;
                    byte_cnt_d   = 2'd2;
                    state_d      = SEND;
                end else if (bus.reg_valid) begin
                    buf_d        = {{DW{1'b0}}, bus.reg_data};
                    reg_ack_d    = 1'b1;
                    last_grant_d = GRANT_REG;
                    byte_cnt_d   = 2'd1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                // Hold off while the UART is still shifting a previous frame.
                if (!bus.tx_busy) begin
                    tx_data_d  = buf_q[DW-1:0];
                    tx_valid_d = 1'b1;
                    to_cnt_d   = '0;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    byte_cnt_d    = 2'd0;
                    state_d       = IDLE;
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    byte_cnt_d = byte_cnt_q - 2'd1;
                    if (byte_cnt_q != 2'd1) begin
                        buf_d   = buf_q >> DW;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        sched_busy_d = (state_d != IDLE);
    end

    // State and registered outputs, cleared asynchronously by RST
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_REG;
            buf_q         <= '0;
            byte_cnt_q    <= '0;
            to_cnt_q      <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            alu_ack_q     <= 1'b0;
            reg_ack_q     <= 1'b0;
            sched_busy_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            buf_q         <= buf_d;
            byte_cnt_q    <= byte_cnt_d;
            to_cnt_q      <= to_cnt_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            alu_ack_q     <= alu_ack_d;
            reg_ack_q     <= reg_ack_d;
            sched_busy_q  <= sched_busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.alu_ack     = alu_ack_q;
    assign bus.reg_ack     = reg_ack_q;
    assign bus.sched_busy  = sched_busy_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched. Each request pushes its expected bytes
// into a queue in the order the arbiter should serve them. A monitor pops and
// compares one entry on every tx_valid pulse. A small UART model raises
// tx_busy two cycles after each load and holds it for ten cycles.
module tb_uart_tx_sched;
    logic clk = 1'b0;
    logic RST;

    always #5 clk = ~clk;

    uart_tx_sched_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_sched #(.DATA_WIDTH(8), .BUSY_TIMEOUT(16)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    int cyc = 0, n_tx = 0, n_alu_ack = 0, n_reg_ack = 0, n_to = 0;
    int tx_cyc = 0, to_cyc = 0;
    bit drop_en = 1'b1, stuck = 1'b0, force_busy = 1'b0;
    int m_t = 0;
    bit m_act = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Wait until the scoreboard is drained and the scheduler is idle
    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            tick();
            k++;
        end while ((exp_q.size() != 0 || bus.sched_busy) && k < budget);
        check("done_sched_idle", bus.sched_busy, 0);
        check("done_sb_drained", exp_q.size(), 0);
    endtask

    // Output monitor / scoreboard consumer
    initial forever begin
        @(posedge clk);
        #2;
        cyc++;
        if (bus.tx_valid) begin
            n_tx++;
            tx_cyc = cyc;
            check("busy_low_at_load", bus.tx_busy, 0);
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("tx_data", bus.tx_data, exp_q.pop_front());
        end
        if (bus.alu_ack) n_alu_ack++;
        if (bus.reg_ack) n_reg_ack++;
        if (bus.timeout_err) begin
            n_to++;
            to_cyc = cyc;
        end
    end

    // Requesters drop valid when they see their ack
    initial forever begin
        @(posedge clk);
        #2;
        if (drop_en && bus.alu_ack) bus.alu_valid = 1'b0;
        if (bus.reg_ack) bus.reg_valid = 1'b0;
    end

    // UART TX model: busy from 2 to 11 cycles after each load
    initial forever begin
        @(negedge clk);
        if (!RST) begin
            m_act = 1'b0;
        end else if (bus.tx_valid && !stuck) begin
            m_act = 1'b1;
            m_t = 0;
        end else if (m_act) begin
            m_t++;
            if (m_t >= 12) m_act = 1'b0;
        end
        bus.tx_busy = force_busy || (m_act && m_t >= 2 && m_t < 12);
    end

    initial begin
        int b_tx, b_alu, b_reg, b_to, k;
        bus.alu_valid = 1'b0;
        bus.alu_data  = '0;
        bus.reg_valid = 1'b0;
        bus.reg_data  = '0;
        bus.tx_busy   = 1'b0;
        RST = 1'b0;

        // Both requests pending from reset: ALU first, then REG
        bus.alu_valid = 1'b1;
        bus.alu_data  = 16'hC0DE;
        bus.reg_valid = 1'b1;
        bus.reg_data  = 8'h77;
        repeat (3) tick();
        check("reset_outputs", {bus.tx_data, bus.tx_valid, bus.alu_ack, bus.reg_ack,
                                bus.sched_busy, bus.timeout_err}, 0);
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h77);
        b_alu = n_alu_ack; b_reg = n_reg_ack;
        RST = 1'b1;
        wait_done(200);
        check("tie1_alu_acks", n_alu_ack - b_alu, 1);
        check("tie1_reg_acks", n_reg_ack - b_reg, 1);

        // Tie again: alternation again gives ALU then REG
        bus.alu_valid = 1'b1;
        bus.alu_data  = 16'hF00D;
        bus.reg_valid = 1'b1;
        bus.reg_data  = 8'h42;
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h42);
        b_alu = n_alu_ack; b_reg = n_reg_ack;
        wait_done(200);
        check("tie2_alu_acks", n_alu_ack - b_alu, 1);
        check("tie2_reg_acks", n_reg_ack - b_reg, 1);

        // Single register byte
        bus.reg_valid = 1'b1;
        bus.reg_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        b_tx = n_tx; b_reg = n_reg_ack;
        wait_done(100);
        check("reg_acks", n_reg_ack - b_reg, 1);
        check("reg_tx_count", n_tx - b_tx, 1);
        check("reg_busy_low_at_idle", bus.tx_busy, 0);

        // ALU result: low byte then high byte
        bus.alu_valid = 1'b1;
        bus.alu_data  = 16'h1234;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        b_tx = n_tx; b_alu = n_alu_ack;
        wait_done(200);
        check("alu_acks", n_alu_ack - b_alu, 1);
        check("alu_tx_count", n_tx - b_tx, 2);

        // UART never goes busy: abort after 16 cycles, high byte dropped
        stuck = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_data  = 16'hBEEF;
        exp_q.push_back(8'hEF);
        b_tx = n_tx; b_to = n_to;
        wait_done(100);
        check("to_pulses", n_to - b_to, 1);
        check("to_latency", to_cyc - tx_cyc, 16);
        repeat (5) tick();
        check("to_tx_count", n_tx - b_tx, 1);
        check("to_still_idle", bus.sched_busy, 0);
        stuck = 1'b0;

        // UART already busy: ack given, load withheld until busy clears
        force_busy = 1'b1;
        tick();
        bus.reg_valid = 1'b1;
        bus.reg_data  = 8'h3C;
        exp_q.push_back(8'h3C);
        b_tx = n_tx; b_reg = n_reg_ack;
        repeat (6) tick();
        check("hold_reg_ack", n_reg_ack - b_reg, 1);
        check("hold_no_tx", n_tx - b_tx, 0);
        check("hold_sched_busy", bus.sched_busy, 1);
        force_busy = 1'b0;
        wait_done(100);
        check("hold_tx_count", n_tx - b_tx, 1);

        // Reset during WAIT_LO of the first ALU byte; held request is resent
        drop_en = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_data  = 16'h5AC3;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h5A);
        b_tx = n_tx;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(n_tx == b_tx + 1 && bus.tx_busy) && k < 60);
        check("rst_reached_wait_lo", bus.tx_busy, 1);
        tick();
        RST = 1'b0;
        #1;
        check("rst_outputs", {bus.tx_data, bus.tx_valid, bus.alu_ack, bus.reg_ack,
                              bus.sched_busy, bus.timeout_err}, 0);
        exp_q.delete();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h5A);
        drop_en = 1'b1;
        repeat (2) tick();
        b_tx = n_tx; b_alu = n_alu_ack;
        RST = 1'b1;
        wait_done(200);
        check("rst_reacked", n_alu_ack - b_alu, 1);
        check("rst_tx_count", n_tx - b_tx, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
